// File: rtl/key_event_scheduler_if.sv
// Event stream from the scheduler to game/UI logic: FWFT head plus valid/ready.
interface key_event_scheduler_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [8:0] evt_code;
  logic [1:0] evt_type;

  modport master (output evt_valid, output evt_code, output evt_type, input evt_ready);
  modport slave  (input evt_valid, input evt_code, input evt_type, output evt_ready);
endinterface

// File: rtl/key_event_scheduler.sv
// Turns PS/2 make/break pulses into an ordered PRESS/RELEASE/REPEAT event FIFO
// with auto-repeat for the most recently pressed key.
module key_event_scheduler #(
  parameter int DEPTH         = 8,
  parameter int CNT_W         = 27,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_valid,
  input  logic [8:0]              last_change,
  input  logic                    key_make,
  input  logic                    rep_en,
  key_event_scheduler_if.master   evt,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow,
  input  logic                    clr_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] T_PRESS   = 2'b01;
  localparam logic [1:0] T_RELEASE = 2'b10;
  localparam logic [1:0] T_REPEAT  = 2'b11;
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_COUNT  = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  state_t           state_reg;
  logic [8:0]       held_code_reg;
  logic [CNT_W-1:0] timer_reg;

  logic [10:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [AW:0]      count_reg, count_next;
  logic             valid_reg, ovf_reg;
  logic [8:0]       head_code_reg;
  logic [1:0]       head_type_reg;
  logic [10:0]      head_next, push_data;

  logic armed, same_code, suppress, tick, dec_push, rep_push, push, pop, full, wr_en;

  assign armed     = rep_en && (state_reg != IDLE);
  assign same_code = (last_change == held_code_reg);
  assign suppress  = armed && key_valid && key_make && same_code;
  assign tick      = armed && (((state_reg == DELAY) && (timer_reg == DELAY_LAST)) ||
                               ((state_reg == REPEAT) && (timer_reg == PERIOD_LAST)));
  assign dec_push  = key_valid && !suppress;
  // A tick that cannot go straight into an empty FIFO is simply lost.
  assign rep_push  = tick && !key_valid && (count_reg == '0);
  assign push      = dec_push || rep_push;
  assign push_data = dec_push ? {(key_make ? T_PRESS : T_RELEASE), last_change}
                              : {T_REPEAT, held_code_reg};
  assign pop       = valid_reg && evt.evt_ready;
  assign full      = (count_reg == FULL_COUNT);
  assign wr_en     = push && (!full || pop);
  assign rd_ptr_next = rd_ptr_reg + AW'(1);

  always_comb begin
    count_next = count_reg;
    if (wr_en && !pop)
      count_next = count_reg + ONE_COUNT;
    else if (!wr_en && pop)
      count_next = count_reg - ONE_COUNT;
  end

  // Head register is the registered read port; it only moves when a new entry surfaces.
  always_comb begin
    head_next = {head_type_reg, head_code_reg};
    if (count_next != '0) begin
      if ((count_reg == '0) || (pop && (count_reg == ONE_COUNT)))
        head_next = push_data;
      else if (pop)
        head_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      valid_reg     <= 1'b0;
      head_code_reg <= '0;
      head_type_reg <= '0;
      ovf_reg       <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_next;
      count_reg <= count_next;
      valid_reg <= (count_next != '0);
      {head_type_reg, head_code_reg} <= head_next;
      if (clr_ovf)
        ovf_reg <= 1'b0;
      else if (push && full && !pop)
        ovf_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      held_code_reg <= '0;
      timer_reg     <= '0;
    end else if (!rep_en) begin
      state_reg <= IDLE;
      timer_reg <= '0;
    end else begin
      if (state_reg != IDLE) begin
        if (tick) begin
          timer_reg <= '0;
          state_reg <= REPEAT;
        end else begin
          timer_reg <= timer_reg + CNT_W'(1);
        end
      end
      // A typematic make of the held key leaves the running schedule untouched.
      if (key_valid) begin
        if (key_make) begin
          if ((state_reg == IDLE) || !same_code) begin
            held_code_reg <= last_change;
            timer_reg     <= '0;
            state_reg     <= DELAY;
          end
        end else if ((state_reg != IDLE) && same_code) begin
          state_reg <= IDLE;
          timer_reg <= '0;
        end
      end
    end
  end

  assign evt.evt_valid = valid_reg;
  assign evt.evt_code  = head_code_reg;
  assign evt.evt_type  = head_type_reg;
  assign fifo_count    = count_reg;
  assign overflow      = ovf_reg;
endmodule

// File: doc/key_event_scheduler.md
Name: key_event_scheduler

Overview:
- Sits between the PS/2 keyboard decoder and game/UI logic.
- Turns the decoder's one-cycle key_valid pulses into an ordered stream of PRESS/RELEASE events, buffered in a FIFO and drained over a valid/ready handshake.
- Generates auto-repeat (REPEAT) events for the most recently pressed key while it stays held, and suppresses the keyboard's own typematic make codes for that key.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CNT_W, 27, width of the repeat timer.
- REPEAT_DELAY, 50_000_000, cycles from PRESS until the first REPEAT (0.5 s at 100 MHz).
- REPEAT_PERIOD, 10_000_000, cycles between successive REPEATs.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- key_valid  in  1  one-cycle pulse from decoder: new make/break received
- last_change  in  9  {extend, scancode} of that event
- key_make  in  1  1 = make (press), 0 = break (release); sampled with key_valid
- rep_en  in  1  auto-repeat enable
- evt_ready  in  1  consumer accepts the event at the head
- evt_valid  out  1  FIFO head holds an event
- evt_code  out  9  code of head event
- evt_type  out  2  01 PRESS, 10 RELEASE, 11 REPEAT (00 never output)
- fifo_count  out  log2(DEPTH)+1  entries currently stored
- overflow  out  1  sticky: an event was dropped
- clr_ovf  in  1  synchronous clear of overflow

Behaviour:
- Reset: FIFO empty, evt_valid=0, evt_code=0, evt_type=00, fifo_count=0, overflow=0, repeat FSM IDLE, held_code=0, timer=0. Reset mid-operation discards all queued events.
- FIFO: registered, first-word-fall-through. An event pushed at edge T into an empty FIFO gives evt_valid=1 after T. Pop occurs when evt_valid and evt_ready are both high at an edge.
- Simultaneous push+pop when full: both take effect; count stays DEPTH.
- Push when full without pop: event dropped, overflow<=1. clr_ovf has priority over a same-cycle set.
- Decoder event (key_valid=1) pushes {type, last_change}, except the suppressed case below. It has priority over a REPEAT in the same cycle.
- Repeat FSM, IDLE:
  - PRESS with rep_en=1 -> held_code<=last_change, timer<=0, go DELAY.
- Repeat FSM, DELAY:
  - timer increments each cycle.
  - When timer==REPEAT_DELAY-1 -> repeat tick, timer<=0, go REPEAT.
- Repeat FSM, REPEAT:
  - timer increments each cycle.
  - When timer==REPEAT_PERIOD-1 -> repeat tick, timer<=0.
- In DELAY or REPEAT:
  - RELEASE of held_code -> go IDLE; the RELEASE itself is enqueued.
  - PRESS of a different code -> held_code<=new code, timer<=0, go DELAY; the PRESS is enqueued.
  - PRESS of held_code (keyboard typematic) -> not enqueued; FSM and timer unchanged.
  - RELEASE of another code -> enqueued; FSM unchanged.
- Repeat tick: pushes {REPEAT, held_code} only if the FIFO is empty and key_valid=0 in that cycle; otherwise the tick is skipped (no deferral, no overflow) and the period restarts.
- rep_en=0: FSM forced to IDLE on the next edge, no REPEATs, no typematic suppression.
- Outputs evt_code/evt_type are undefined-free: they hold the last head value when evt_valid=0.
- Order is preserved: events leave in push order.

Test Plan:
- Reset, then key_valid pulse with code 0x01C and key_make=1 -> next cycle evt_valid=1, evt_code=0x01C, evt_type=01, fifo_count=1. Then evt_ready=1 for one cycle -> evt_valid=0, fifo_count=0.
- With DELAY=20, PERIOD=5, rep_en=1, evt_ready=1: press 0x01C and hold -> REPEAT for 0x01C at 20 cycles after the PRESS, then every 5 cycles. Release 0x01C -> RELEASE event, and no further REPEATs.
- While 0x01C is held, inject typematic makes of 0x01C -> none enqueued. A make of 0x11D mid-DELAY -> PRESS 0x11D enqueued, repeats now for 0x11D, timer restarted.
- evt_ready=0, 9 decoder events with DEPTH=8 -> fifo_count=8, overflow=1, 9th event lost. First 8 drain in order. clr_ovf -> overflow=0.
- FIFO full with key_valid and evt_ready both high in the same cycle -> count stays 8, new event becomes the tail, overflow stays 0.
- Repeat tick coinciding with key_valid, or with a non-empty FIFO -> no REPEAT pushed, next REPEAT exactly PERIOD cycles later. Assert rst mid-stream -> all outputs return to reset values immediately.
